regfile_wb_scheduler: RTL
=========================

Name: regfile_wb_scheduler

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU result) and req1 (load/memory result).
- Arbitration is round-robin. Each requester has a valid/ready handshake.
- Drives the register-file write controls from registers, giving a fixed one-cycle latency.
- Keeps a per-register busy scoreboard: issue logic reserves a destination register, and the busy bit clears on the same edge the register file commits the write.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width; the block tracks 2**ADDR_W registers.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU writeback request.
- req0_reg  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req0_ready  out  1  req0 granted this cycle.
- req1_valid  in  1  load writeback request.
- req1_reg  in  ADDR_W  load destination register.
- req1_data  in  DATA_W  load data.
- req1_ready  out  1  req1 granted this cycle.
- rsv_valid  in  1  reserve a destination register (instruction issue).
- rsv_reg  in  ADDR_W  register to mark busy.
- q1_reg  in  ADDR_W  scoreboard query 1.
- q2_reg  in  ADDR_W  scoreboard query 2.
- q1_busy  out  1  q1_reg has a pending write (combinational).
- q2_busy  out  1  q2_reg has a pending write (combinational).
- busy_any  out  1  OR of all busy bits.
- RegWrite  out  1  register-file write enable (registered).
- WriteRegister  out  ADDR_W  register-file write index (registered).
- WriteData  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset: one clock domain (clk); rst is synchronous and active-high. While rst=1:
  - req0_ready=0, req1_ready=0.
  - At the edge: RegWrite<=0, WriteRegister<=0, WriteData<=0, all busy bits<=0, priority pointer<=0 (req0 favoured).
- Arbitration (combinational, rst=0):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester indicated by the pointer gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
  - At most one ready is high per cycle.
  - The output stage drains every cycle, so a grant never stalls on the register file.
- Pointer update: on any grant, pointer <= index of the non-granted requester (pointer <= 1 after a req0 grant, <= 0 after a req1 grant). No grant leaves the pointer unchanged.
- Handshake:
  - A transfer occurs at an edge where valid=1 and ready=1.
  - A requester keeps valid, reg and data stable until accepted.
  - A losing requester waits at most one cycle.
- Output stage:
  - A transfer accepted at edge N with reg!=0 gives RegWrite=1, WriteRegister=reg, WriteData=data during cycle N+1. The register file commits at edge N+1.
  - No transfer, or transfer to reg 0, gives RegWrite=0 at N+1. A reg-0 transfer is still accepted (ready=1) and the data is discarded.
  - WriteRegister/WriteData hold their last values when RegWrite=0.
- Scoreboard:
  - busy[r] sets at an edge where rsv_valid=1 and rsv_reg=r, for r!=0.
  - busy[r] clears at an edge where RegWrite=1 and WriteRegister=r.
  - The clear coincides with the register-file commit, so a reader never sees busy=0 with stale data.
  - Set and clear on the same r at the same edge: set wins, busy stays 1 (newer producer).
  - Set and clear on different registers at the same edge: both take effect.
  - busy[0] is constant 0; reserving reg 0 is ignored.
  - Re-reserving an already-busy register keeps it 1 (no count).
  - Two in-flight writes to the same register are not tracked separately; issue logic must not reserve a register already busy.
- Queries:
  - qN_busy = busy[qN_reg], combinational from current state.
  - busy_any = OR of all busy bits, combinational.
- Reset mid-operation: a write pending in the output stage is dropped (RegWrite=0 the cycle after reset), all reservations are lost, and the pointer returns to 0.

Test Plan:
- Reset: assert rst 2 cycles with req0_valid=1 -> req0_ready=0, RegWrite=0, busy_any=0, q1_busy=0 for q1_reg=7.
- Single write: rsv r5; next cycle req0 {r5, 0xDEADBEEF} -> q1_busy(r5)=1; req0_ready=1; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; q1_busy(r5)=0 after that edge.
- Contention: req0 {r3,0x11} and req1 {r4,0x22} held valid from reset -> grant req0 first, then req1 -> RegWrite pulses r3/0x11 then r4/0x22 on consecutive cycles; a later tie goes to req0 again.
- Reg 0: req1 {r0, 0xFFFFFFFF}; rsv r0 -> req1_ready=1, RegWrite stays 0, q1_busy(r0)=0.
- Same-edge set/clear: write to r9 in the output stage while rsv r9 is asserted -> q1_busy(r9)=1 after the edge.
- Reset mid-flight: accept req0 {r6,0x55} then assert rst the next cycle -> RegWrite=0 the cycle after reset, busy_any=0, pointer favours req0.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Shares the register file's single write port between two writeback
// requesters: req0 (ALU result) and req1 (load result). The arbiter is
// round-robin. The register-file write controls come from registers, so a
// write is seen one cycle after its request is accepted. The block also keeps
// a per-register busy scoreboard. Issue logic sets a busy bit, and the bit
// clears on the edge where the register file commits the write.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   req0_valid/reg/data/ready  ALU writeback handshake
//   req1_valid/reg/data/ready  load writeback handshake
//   rsv_valid, rsv_reg         reserve a destination register at issue
//   q1_reg/q1_busy             scoreboard query port 1 (combinational)
//   q2_reg/q2_busy             scoreboard query port 2 (combinational)
//   busy_any                   OR of all busy bits
//   RegWrite, WriteRegister,   registered register-file write controls
//   WriteData
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] q1_reg,
  input  logic [ADDR_W-1:0] q2_reg,
  output logic              q1_busy,
  output logic              q2_busy,
  output logic              busy_any,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData
);

  localparam int NREG = 2 ** ADDR_W;

  logic            ptr;        // 0: req0 wins a tie, 1: req1 wins a tie
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            grant0;
  logic            grant1;

  // The output register drains every cycle, so a grant depends only on the
  // valids and the pointer. Grants are held low while rst is high.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || !ptr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The clear is applied before the set. When both hit the same register, the
  // newer producer's reservation therefore survives. Bit 0 is forced low.
  always_comb begin
    busy_next = busy;
    if (RegWrite) begin
      busy_next[WriteRegister] = 1'b0;
    end
    if (rsv_valid && (rsv_reg != '0)) begin
      busy_next[rsv_reg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples values from before the edge, whatever the statement order.
    if (rst) begin
      // NOTE: the busy array is real control state, not a data memory. It
      // must come out of reset empty, so every bit is reset.
      busy          <= '0;
      ptr           <= 1'b0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      busy <= busy_next;
      if (grant0) begin
        ptr      <= 1'b1;
        RegWrite <= (req0_reg != '0);
        // A write to reg 0 is accepted but discarded. The previous
        // index and data are kept.
        if (req0_reg != '0) begin
          WriteRegister <= req0_reg;
          WriteData     <= req0_data;
        end
      end else if (grant1) begin
        ptr      <= 1'b0;
        RegWrite <= (req1_reg != '0);
        if (req1_reg != '0) begin
          WriteRegister <= req1_reg;
          WriteData     <= req1_data;
        end
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  assign q1_busy  = busy[q1_reg];
  assign q2_busy  = busy[q2_reg];
  assign busy_any = |busy;

endmodule
